// File: rtl/ts_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ts_pkg
// Description : Shared MPEG-TS constants, the stuffer state encoding and a
//               helper that returns byte N of a PID 0x1FFF null packet.
// Revision    : 1.0 - initial release
// ============================================================================
package ts_pkg;

    localparam int          PKT_LEN      = 188;
    localparam logic [7:0]  TS_SYNC_BYTE = 8'h47;
    localparam logic [12:0] NULL_PID     = 13'h1FFF;
    localparam logic [7:0]  NULL_HDR3    = 8'h10;
    localparam logic [7:0]  STUFF_BYTE   = 8'hFF;

    typedef enum logic [1:0] {
        ST_DECIDE = 2'd0,
        ST_FWD    = 2'd1,
        ST_NULL   = 2'd2,
        ST_HUNT   = 2'd3
    } ts_state_t;

    // Header: 47 | TEI/PUSI/prio=0, PID[12:8] | PID[7:0] | AFC=01, CC=0.
    // Everything after the 4-byte header is stuffing.
    function automatic logic [7:0] null_byte(input logic [7:0] idx);
        logic [7:0] b;
        case (idx)
            8'd0:    b = TS_SYNC_BYTE;
            8'd1:    b = {3'b000, NULL_PID[12:8]};
            8'd2:    b = NULL_PID[7:0];
            8'd3:    b = NULL_HDR3;
            default: b = STUFF_BYTE;
        endcase
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ts_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : ts_sat_counter
// Description : Event counter that sticks at all-ones.
// Ports       : CLK  - clock
//               RST  - synchronous reset, active-low
//               inc  - count one event this cycle
//               q    - current count
// Revision    : 1.0 - initial release
// ============================================================================
module ts_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             inc,
    output logic [CNT_W-1:0] q
);

    localparam logic [CNT_W-1:0] c_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_q;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_q <= '0;
        end else if (inc && (r_q != '1)) begin
            r_q <= r_q + c_ONE;
        end
    end

    assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/ts_null_stuffer.sv
`default_nettype none
// ============================================================================
// Module      : ts_null_stuffer
// Description : Reads whole 188-byte packets from a show-ahead FIFO and
//               drives a constant-rate TS stream, inserting PID 0x1FFF null
//               packets whenever a complete packet is not available and
//               discarding bytes until a p_sync-marked head is found.
// Ports       : CLK          - 27 MHz clock
//               RST          - synchronous reset, active-low
//               ENABLE       - allow new packets to start
//               FIFO_DATA    - FIFO head {p_sync, byte}
//               FIFO_EMPTY   - FIFO empty flag
//               FIFO_USEDW   - FIFO fill level in words
//               FIFO_RDREQ   - pop the FIFO head this cycle
//               DATA_OUT     - TS byte
//               D_VALID_OUT  - DATA_OUT valid
//               P_SYNC_OUT   - first byte of an output packet
//               NULL_CNT     - null packets inserted (saturating)
//               DROP_CNT     - bytes dropped while hunting (saturating)
//               UNDER_CNT    - underrun stall cycles (saturating)
// Revision    : 1.0 - initial release
// ============================================================================
module ts_null_stuffer #(
    parameter int PKT_LEN = 188,
    parameter int USEDW_W = 10,
    parameter int CNT_W   = 16
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               ENABLE,
    input  logic [8:0]         FIFO_DATA,
    input  logic               FIFO_EMPTY,
    input  logic [USEDW_W-1:0] FIFO_USEDW,
    output logic               FIFO_RDREQ,
    output logic [7:0]         DATA_OUT,
    output logic               D_VALID_OUT,
    output logic               P_SYNC_OUT,
    output logic [CNT_W-1:0]   NULL_CNT,
    output logic [CNT_W-1:0]   DROP_CNT,
    output logic [CNT_W-1:0]   UNDER_CNT
);

    import ts_pkg::*;

    localparam logic [7:0]         c_LAST_IDX  = 8'(PKT_LEN - 1);
    localparam logic [USEDW_W-1:0] c_PKT_WORDS = USEDW_W'(PKT_LEN);

    ts_state_t  r_state;
    ts_state_t  w_state_nxt;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_nxt;
    logic [7:0] r_data;
    logic [7:0] w_data_nxt;
    logic       r_valid;
    logic       w_valid_nxt;
    logic       r_psync;
    logic       w_psync_nxt;
    logic       w_rdreq;
    logic       w_null_inc;
    logic       w_drop_inc;
    logic       w_under_inc;
    logic       w_head_sync;

    assign w_head_sync = FIFO_DATA[8];

    // ------------------------------------------------------------------
    // State, byte counter and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state <= ST_DECIDE;
            r_cnt   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_psync <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_data  <= w_data_nxt;
            r_valid <= w_valid_nxt;
            r_psync <= w_psync_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state / next output. DECIDE both chooses and emits byte 0 so
    // consecutive packets leave no idle cycle between them.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_data_nxt  = 8'h00;
        w_valid_nxt = 1'b0;
        w_psync_nxt = 1'b0;
        w_rdreq     = 1'b0;
        w_null_inc  = 1'b0;
        w_drop_inc  = 1'b0;
        w_under_inc = 1'b0;

        case (r_state)
            ST_DECIDE: begin
                if (ENABLE) begin
                    if ((FIFO_USEDW >= c_PKT_WORDS) && w_head_sync) begin
                        w_state_nxt = ST_FWD;
                        w_rdreq     = 1'b1;
                        w_data_nxt  = FIFO_DATA[7:0];
                        w_valid_nxt = 1'b1;
                        w_psync_nxt = 1'b1;
                        w_cnt_nxt   = 8'd1;
                    end else if (!FIFO_EMPTY && !w_head_sync) begin
                        w_state_nxt = ST_HUNT;
                    end else begin
                        w_state_nxt = ST_NULL;
                        w_data_nxt  = null_byte(8'd0);
                        w_valid_nxt = 1'b1;
                        w_psync_nxt = 1'b1;
                        w_cnt_nxt   = 8'd1;
                    end
                end
            end

            ST_FWD: begin
                // Only byte 0 carries P_SYNC_OUT; stray p_sync flags inside
                // the packet body are deliberately not propagated.
                if (!FIFO_EMPTY) begin
                    w_rdreq     = 1'b1;
                    w_data_nxt  = FIFO_DATA[7:0];
                    w_valid_nxt = 1'b1;
                    if (r_cnt == c_LAST_IDX) begin
                        w_state_nxt = ST_DECIDE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt   = r_cnt + 8'd1;
                    end
                end else begin
                    // Stall in place; the packet resumes at the same byte.
                    w_under_inc = 1'b1;
                end
            end

            ST_NULL: begin
                w_data_nxt  = null_byte(r_cnt);
                w_valid_nxt = 1'b1;
                if (r_cnt == c_LAST_IDX) begin
                    w_state_nxt = ST_DECIDE;
                    w_cnt_nxt   = '0;
                    w_null_inc  = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt + 8'd1;
                end
            end

            ST_HUNT: begin
                // A sync-marked head is left in the FIFO for DECIDE to use.
                if (!FIFO_EMPTY && !w_head_sync) begin
                    w_rdreq    = 1'b1;
                    w_drop_inc = 1'b1;
                end else begin
                    w_state_nxt = ST_DECIDE;
                end
            end

            default: begin
                w_state_nxt = ST_DECIDE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // The pop has to act on the head in the same cycle, so it cannot be
    // delayed by a register; it is held off while reset is asserted.
    assign FIFO_RDREQ  = w_rdreq & RST;
    assign DATA_OUT    = r_data;
    assign D_VALID_OUT = r_valid;
    assign P_SYNC_OUT  = r_psync;

    // ------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------
    ts_sat_counter #(.CNT_W(CNT_W)) u_null_cnt (
        .CLK (CLK),
        .RST (RST),
        .inc (w_null_inc),
        .q   (NULL_CNT)
    );

    ts_sat_counter #(.CNT_W(CNT_W)) u_drop_cnt (
        .CLK (CLK),
        .RST (RST),
        .inc (w_drop_inc),
        .q   (DROP_CNT)
    );

    ts_sat_counter #(.CNT_W(CNT_W)) u_under_cnt (
        .CLK (CLK),
        .RST (RST),
        .inc (w_under_inc),
        .q   (UNDER_CNT)
    );

endmodule
`default_nettype wire

// File: tb/tb_ts_null_stuffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ts_null_stuffer
// Description : Self-checking bench for ts_null_stuffer. A queue models the
//               show-ahead FIFO; expected output bytes are queued as
//               stimulus is prepared and compared as the DUT emits them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ts_null_stuffer;

    localparam int PKT = 188;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        ENABLE = 1'b0;
    logic [8:0]  FIFO_DATA = 9'h000;
    logic        FIFO_EMPTY = 1'b1;
    logic [9:0]  FIFO_USEDW = 10'd0;
    logic        FIFO_RDREQ;
    logic [7:0]  DATA_OUT;
    logic        D_VALID_OUT;
    logic        P_SYNC_OUT;
    logic [15:0] NULL_CNT;
    logic [15:0] DROP_CNT;
    logic [15:0] UNDER_CNT;

    always #5 CLK = ~CLK;

    ts_null_stuffer #(
        .PKT_LEN (PKT),
        .USEDW_W (10),
        .CNT_W   (16)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .ENABLE      (ENABLE),
        .FIFO_DATA   (FIFO_DATA),
        .FIFO_EMPTY  (FIFO_EMPTY),
        .FIFO_USEDW  (FIFO_USEDW),
        .FIFO_RDREQ  (FIFO_RDREQ),
        .DATA_OUT    (DATA_OUT),
        .D_VALID_OUT (D_VALID_OUT),
        .P_SYNC_OUT  (P_SYNC_OUT),
        .NULL_CNT    (NULL_CNT),
        .DROP_CNT    (DROP_CNT),
        .UNDER_CNT   (UNDER_CNT)
    );

    logic [8:0] fq[$];      // FIFO contents, head at index 0
    logic [8:0] exp_q[$];   // expected {p_sync, byte} output stream
    bit         force_empty;
    bit         mon_en;
    bit         rd_s;
    int         gap_cnt;
    int         n_chk;
    int         n_fail;

    typedef struct {
        int         nw;
        logic       sync;
        logic       en;
        logic       rd0;
        logic       val;
        logic [7:0] dat;
        logic       ps;
        logic       rd1;
    } dec_t;

    dec_t tbl[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] nb(input int i);
        if (i == 0) return 8'h47;
        if (i == 1) return 8'h1F;
        if (i == 2) return 8'hFF;
        if (i == 3) return 8'h10;
        return 8'hFF;
    endfunction

    function automatic logic [7:0] pkt_byte(input int cc, input int i);
        if (i == 0) return 8'h47;
        if (i == 1) return 8'h01;
        if (i == 2) return 8'h00;
        if (i == 3) return 8'(8'h10 + cc);
        return 8'(i * 3 + cc * 17);
    endfunction

    task automatic push_null_exp();
        for (int i = 0; i < PKT; i++) exp_q.push_back({(i == 0), nb(i)});
    endtask

    task automatic exp_pkt(input int cc);
        for (int i = 0; i < PKT; i++) exp_q.push_back({(i == 0), pkt_byte(cc, i)});
    endtask

    task automatic load_pkt(input int cc, input int first, input int last);
        for (int i = first; i <= last; i++) fq.push_back({(i == 0), pkt_byte(cc, i)});
    endtask

    task automatic drive_fifo();
        FIFO_EMPTY = force_empty || (fq.size() == 0);
        FIFO_DATA  = (fq.size() != 0) ? fq[0] : 9'h000;
        FIFO_USEDW = (fq.size() > 1023) ? 10'h3FF : 10'(fq.size());
    endtask

    // One clock: inputs settle, pop decision sampled before the edge, FIFO
    // model updated after it, outputs checked on the falling edge.
    task automatic cycle();
        logic [8:0] e;
        drive_fifo();
        #1;
        rd_s = FIFO_RDREQ;
        @(posedge CLK);
        #1;
        if (rd_s && fq.size() > 0) void'(fq.pop_front());
        drive_fifo();
        @(negedge CLK);
        if (mon_en) begin
            if (D_VALID_OUT) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL out_extra: got %0h, expected no output", {P_SYNC_OUT, DATA_OUT});
                end else begin
                    e = exp_q.pop_front();
                    chk("out_byte", 32'({P_SYNC_OUT, DATA_OUT}), 32'(e));
                end
            end else begin
                gap_cnt++;
            end
        end
    endtask

    task automatic do_reset();
        mon_en      = 1'b0;
        RST         = 1'b0;
        force_empty = 1'b0;
        fq.delete();
        exp_q.delete();
        cycle();
        cycle();
        RST     = 1'b1;
        gap_cnt = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk = 0;
        n_fail = 0;

        // ---------------- reset state ----------------
        ENABLE = 1'b1;
        do_reset();
        chk("rst_data",   32'(DATA_OUT),    32'd0);
        chk("rst_valid",  32'(D_VALID_OUT), 32'd0);
        chk("rst_psync",  32'(P_SYNC_OUT),  32'd0);
        chk("rst_rdreq",  32'(rd_s),        32'd0);
        chk("rst_null",   32'(NULL_CNT),    32'd0);
        chk("rst_drop",   32'(DROP_CNT),    32'd0);
        chk("rst_under",  32'(UNDER_CNT),   32'd0);

        // ---------------- DECIDE table ----------------
        //           nw   sync  en    rd0   val   dat    ps    rd1
        tbl[0] = '{200, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[1] = '{0,   1'b0, 1'b1, 1'b0, 1'b1, 8'h47, 1'b1, 1'b0};
        tbl[2] = '{200, 1'b1, 1'b1, 1'b1, 1'b1, 8'h5A, 1'b1, 1'b1};
        tbl[3] = '{187, 1'b1, 1'b1, 1'b0, 1'b1, 8'h47, 1'b1, 1'b0};
        tbl[4] = '{188, 1'b1, 1'b1, 1'b1, 1'b1, 8'h5A, 1'b1, 1'b1};
        tbl[5] = '{10,  1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
        tbl[6] = '{1,   1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
        tbl[7] = '{189, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
        for (int t = 0; t < 8; t++) begin
            ENABLE = tbl[t].en;
            do_reset();
            for (int i = 0; i < tbl[t].nw; i++)
                fq.push_back((i == 0) ? {tbl[t].sync, 8'h5A} : 9'h0AA);
            cycle();
            chk($sformatf("dec%0d_rdreq", t), 32'(rd_s),        32'(tbl[t].rd0));
            chk($sformatf("dec%0d_valid", t), 32'(D_VALID_OUT), 32'(tbl[t].val));
            chk($sformatf("dec%0d_data", t),  32'(DATA_OUT),    32'(tbl[t].dat));
            chk($sformatf("dec%0d_psync", t), 32'(P_SYNC_OUT),  32'(tbl[t].ps));
            cycle();
            chk($sformatf("dec%0d_rdreq2", t), 32'(rd_s), 32'(tbl[t].rd1));
        end

        // ---------------- 1: empty FIFO -> 10 null packets ----------------
        ENABLE = 1'b1;
        do_reset();
        for (int p = 0; p < 10; p++) push_null_exp();
        mon_en = 1'b1;
        repeat (10 * PKT) cycle();
        chk("t1_null_cnt", 32'(NULL_CNT),      32'd10);
        chk("t1_gaps",     32'(gap_cnt),       32'd0);
        chk("t1_left",     32'(exp_q.size()),  32'd0);

        // ---------------- 2: two packets back to back ----------------
        do_reset();
        load_pkt(0, 0, PKT - 1);
        load_pkt(1, 0, PKT - 1);
        exp_pkt(0);
        exp_pkt(1);
        mon_en = 1'b1;
        cycle();
        chk("t2_first_pop",   32'(rd_s),        32'd1);
        chk("t2_first_valid", 32'(D_VALID_OUT), 32'd1);
        repeat (2 * PKT - 1) cycle();
        chk("t2_gaps",     32'(gap_cnt),      32'd0);
        chk("t2_left",     32'(exp_q.size()), 32'd0);
        chk("t2_fifo",     32'(fq.size()),    32'd0);
        chk("t2_null_cnt", 32'(NULL_CNT),     32'd0);

        // ---------------- 3: garbage then a packet ----------------
        do_reset();
        fq.push_back(9'h047);
        fq.push_back(9'h000);
        fq.push_back(9'h011);
        fq.push_back(9'h022);
        fq.push_back(9'h033);
        load_pkt(2, 0, PKT - 1);
        exp_pkt(2);
        mon_en = 1'b1;
        repeat (7 + PKT) cycle();
        chk("t3_drop_cnt", 32'(DROP_CNT),     32'd5);
        chk("t3_gaps",     32'(gap_cnt),      32'd7);
        chk("t3_left",     32'(exp_q.size()), 32'd0);
        chk("t3_fifo",     32'(fq.size()),    32'd0);
        chk("t3_null_cnt", 32'(NULL_CNT),     32'd0);

        // ---------------- 4: partial packet -> null first ----------------
        do_reset();
        push_null_exp();
        exp_pkt(3);
        load_pkt(3, 0, 99);
        mon_en = 1'b1;
        repeat (60) cycle();
        chk("t4_no_read", 32'(fq.size()), 32'd100);
        load_pkt(3, 100, PKT - 1);
        repeat (2 * PKT - 60) cycle();
        chk("t4_gaps",     32'(gap_cnt),      32'd0);
        chk("t4_null_cnt", 32'(NULL_CNT),     32'd1);
        chk("t4_left",     32'(exp_q.size()), 32'd0);
        chk("t4_fifo",     32'(fq.size()),    32'd0);

        // ---------------- 5: underrun at byte 50 ----------------
        do_reset();
        load_pkt(4, 0, PKT - 1);
        exp_pkt(4);
        mon_en = 1'b1;
        repeat (50) cycle();
        force_empty = 1'b1;
        repeat (3) cycle();
        force_empty = 1'b0;
        repeat (PKT - 50) cycle();
        chk("t5_under_cnt", 32'(UNDER_CNT),    32'd3);
        chk("t5_gaps",      32'(gap_cnt),      32'd3);
        chk("t5_left",      32'(exp_q.size()), 32'd0);
        chk("t5_fifo",      32'(fq.size()),    32'd0);

        // ---------------- 6: reset in the middle of a null packet ----------------
        do_reset();
        fq.push_back(9'h047);
        fq.push_back(9'h001);
        fq.push_back(9'h002);
        fq.push_back(9'h003);
        fq.push_back(9'h004);
        push_null_exp();
        mon_en = 1'b1;
        repeat (98) cycle();
        chk("t6_drop_pre",  32'(DROP_CNT), 32'd5);
        chk("t6_byte90",    32'({D_VALID_OUT, P_SYNC_OUT, DATA_OUT}), 32'h2FF);
        RST = 1'b0;
        cycle();
        chk("t6_rst_valid", 32'(D_VALID_OUT), 32'd0);
        chk("t6_rst_data",  32'(DATA_OUT),    32'd0);
        chk("t6_rst_psync", 32'(P_SYNC_OUT),  32'd0);
        chk("t6_rst_drop",  32'(DROP_CNT),    32'd0);
        chk("t6_rst_null",  32'(NULL_CNT),    32'd0);
        chk("t6_rst_under", 32'(UNDER_CNT),   32'd0);
        RST = 1'b1;
        exp_q.delete();
        push_null_exp();
        gap_cnt = 0;
        repeat (PKT) cycle();
        chk("t6_null_cnt", 32'(NULL_CNT),     32'd1);
        chk("t6_gaps",     32'(gap_cnt),      32'd0);
        chk("t6_left",     32'(exp_q.size()), 32'd0);

        // ---------------- 7: ENABLE dropped mid-packet ----------------
        ENABLE = 1'b1;
        do_reset();
        push_null_exp();
        mon_en = 1'b1;
        repeat (100) cycle();
        ENABLE = 1'b0;
        repeat (150) cycle();
        chk("t7_null_cnt", 32'(NULL_CNT),     32'd1);
        chk("t7_gaps",     32'(gap_cnt),      32'd62);
        chk("t7_left",     32'(exp_q.size()), 32'd0);
        chk("t7_idle",     32'(D_VALID_OUT),  32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
